uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver and the successor to the fixed 8N1 receiver in the loopback designs. Data width, parity mode and stop-bit count are configurable. Each bit is decided by a 3-sample majority vote at mid-bit, and start bits are validated so line glitches are rejected. The received word sits in a holding register and is delivered on a valid/ready handshake, with parity, framing and overrun flags. It sits between the uart_rxd pin and downstream logic such as a loopback, FIFO or command parser.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
UART_BPS, 115200, baud rate; BPS_CNT = CLK_FREQ/UART_BPS (434 at defaults), must be >= 8
DATA_BITS, 8, data bits per frame, legal range 5..9, sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
sys_clk  input  1  system clock; all logic on rising edge
sys_rst  input  1  synchronous reset, active-high
uart_rxd  input  1  asynchronous serial line; idle high
rx_data  output  DATA_BITS  received word, stable while rx_valid=1
rx_valid  output  1  holding register full
rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready
parity_err  output  1  parity mismatch for the held word; qualified by rx_valid
frame_err  output  1  a stop bit was sampled 0 for the held word; qualified by rx_valid
overrun_err  output  1  one-cycle pulse: a completed frame was dropped because the holder was full
rx_busy  output  1  FSM not in IDLE

Behaviour:
- Reset (sys_rst=1 at a clock edge) applies on that edge, including mid-frame:
  - synchroniser flops = 1; FSM = IDLE; counters = 0.
  - rx_data = 0; rx_valid, parity_err, frame_err, overrun_err, rx_busy = 0.
- Synchroniser: 2 flops on uart_rxd (rxd_s). Start detect = falling edge of rxd_s (previous 1, current 0), checked only in IDLE.
- Bit timer: clk_cnt, width clog2(BPS_CNT), runs 0..BPS_CNT-1 in every non-IDLE state and wraps to 0.
  - It is cleared on the start-detect cycle, so count 0 aligns to the first low cycle.
- Majority vote: rxd_s is sampled at clk_cnt = BPS_CNT/2-1, BPS_CNT/2 and BPS_CNT/2+1 (integer division). The bit value is the 2-of-3 majority, decided at BPS_CNT/2+1 (the "decision point").
- FSM states:
  - IDLE: start detect -> START.
  - START: at the decision point, bit=1 -> IDLE (false start, no flags, no output); bit=0 -> continue. At wrap -> DATA.
  - DATA: at each decision point, shift the bit into a shift register (LSB first) and increment bit_idx. At wrap after bit_idx reaches DATA_BITS -> PARITY if PARITY != 0, else STOP.
  - PARITY: at the decision point, compute the error. Odd: XOR(data, bit) must be 1. Even: XOR(data, bit) must be 0. At wrap -> STOP.
  - STOP: at each stop bit's decision point, a 0 sets the frame-error accumulator. At the decision point of the last stop bit, issue "frame done" and go directly to IDLE. Do not wait for the bit end, so back-to-back frames are caught.
- Frame done, with registered outputs updated on the next edge:
  - If rx_valid=0, or rx_valid & rx_ready in the same cycle: load rx_data, parity_err and frame_err; rx_valid=1.
  - Otherwise the new frame is discarded, overrun_err=1 for exactly one cycle, and the held word and flags are unchanged.
- Handshake: rx_valid & rx_ready with no simultaneous load -> rx_valid=0 on the next edge. rx_data and error flags keep their last value but are don't-care.
- Frames with parity or framing errors are still delivered, with their flags set.
- Break (line held low): the frame ends with frame_err=1. No new start is detected until rxd_s returns high, because detection is edge-based.
- Latency: rx_valid rises one cycle after the last stop bit's decision point, which is about (1 + DATA_BITS + P + STOP_BITS - 0.5) bit times after the start edge, plus 2 synchroniser cycles. P = 1 if PARITY != 0, else 0.
- rx_busy = 1 from the cycle after start detect until the FSM returns to IDLE.

Test Plan:
1. Defaults (8N1, BPS_CNT=434), send 0x55 with rx_ready=1 -> rx_valid pulses 1 cycle with rx_data=0x55, parity_err=0, frame_err=0; rx_busy low after.
2. PARITY=2, send 0xA3 with parity bit 0 (correct) then 0xA3 with parity bit 1 -> first word parity_err=0, second parity_err=1, both rx_data=0xA3.
3. Send 0x3C with stop bit 0, then hold the line low for 20 bit times, then high, then send 0x81 -> first word frame_err=1; no frame during the low hold; 0x81 is received cleanly.
4. Low glitch of 100 cycles on an idle line; separately, a single-cycle high spike mid-data-bit of 0xF0 -> no rx_valid after the glitch; the spike is voted out and 0xF0 is received.
5. rx_ready=0, send 0x11 and 0x22 back-to-back -> rx_data=0x11 held with rx_valid=1; overrun_err pulses once at the second frame's done; after the rx_ready pulse, rx_valid=0 and 0x22 is never presented.
6. DATA_BITS=7, STOP_BITS=2, PARITY=1: send 0x5A; assert sys_rst mid-data on a later frame -> 0x5A is delivered correctly; after reset, all outputs are 0 and the next full frame is received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample mid-bit majority vote,
// validated start bit, valid/ready holding register with parity/framing/overrun flags.
module uart_rx_param #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int UART_BPS  = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CW      = $clog2(BPS_CNT);
  localparam int IW      = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] SMP0 = CW'(BPS_CNT / 2 - 1);
  localparam logic [CW-1:0] SMP1 = CW'(BPS_CNT / 2);
  localparam logic [CW-1:0] DEC  = CW'(BPS_CNT / 2 + 1);
  localparam logic [CW-1:0] LAST = CW'(BPS_CNT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state;
  logic                 sync1, rxd_s, rxd_prev;
  logic [CW-1:0]        clk_cnt;
  logic [1:0]           samp;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr, ferr;
  logic                 at_dec, at_wrap, bit_v, frame_done;

  assign at_dec     = (clk_cnt == DEC);
  assign at_wrap    = (clk_cnt == LAST);
  // third sample is the live rxd_s at the decision point
  assign bit_v      = (samp[0] & samp[1]) | (samp[0] & rxd_s) | (samp[1] & rxd_s);
  assign frame_done = (state == S_STOP) && at_dec && (stop_idx == 1'(STOP_BITS - 1));
  assign rx_busy    = (state != S_IDLE);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1       <= 1'b1;
      rxd_s       <= 1'b1;
      rxd_prev    <= 1'b1;
      state       <= S_IDLE;
      clk_cnt     <= '0;
      samp        <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      shreg       <= '0;
      perr        <= 1'b0;
      ferr        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      sync1       <= uart_rxd;
      rxd_s       <= sync1;
      rxd_prev    <= rxd_s;
      overrun_err <= 1'b0;

      // a finishing frame may load in the same cycle the old word is taken
      if (frame_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= perr;
          frame_err  <= ferr | ~bit_v;
          rx_valid   <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (state != S_IDLE) clk_cnt <= at_wrap ? '0 : clk_cnt + CW'(1);
      if (clk_cnt == SMP0) samp[0] <= rxd_s;
      if (clk_cnt == SMP1) samp[1] <= rxd_s;

      case (state)
        S_IDLE: begin
          if (rxd_prev && !rxd_s) begin
            state    <= S_START;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
          end
        end
        S_START: begin
          if (at_dec && bit_v) state <= S_IDLE;
          else if (at_wrap)    state <= S_DATA;
        end
        S_DATA: begin
          if (at_dec) begin
            shreg   <= {bit_v, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + IW'(1);
          end
          if (at_wrap && bit_idx == IW'(DATA_BITS))
            state <= (PARITY != 0) ? S_PAR : S_STOP;
        end
        S_PAR: begin
          if (at_dec) perr <= (PARITY == 1) ? ~(^shreg ^ bit_v) : (^shreg ^ bit_v);
          if (at_wrap) state <= S_STOP;
        end
        S_STOP: begin
          // leave at mid-bit of the last stop so a back-to-back start edge is seen
          if (at_dec) begin
            if (!bit_v) ferr <= 1'b1;
            if (stop_idx == 1'(STOP_BITS - 1)) state <= S_IDLE;
          end
          if (at_wrap) stop_idx <= stop_idx + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 8E1, 7O2) checked every cycle
// against a frame-level timing model, plus hand-computed literal expectations.
module tb_uart_rx_param;

  localparam int CF  = 1_000_000;
  localparam int BPS = 20_000;
  localparam int B   = CF / BPS;
  localparam int H   = B / 2;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [2:0] rxd = '1;
  logic [2:0] rdy = '0;
  logic [7:0] d_a, d_b;
  logic [6:0] d_c;
  logic v_a, v_b, v_c, pe_a, pe_b, pe_c, fe_a, fe_b, fe_c;
  logic ov_a, ov_b, ov_c, bz_a, bz_b, bz_c;

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_FREQ(CF), .UART_BPS(BPS)) u_a (
    .sys_clk(clk), .sys_rst(sys_rst), .uart_rxd(rxd[0]), .rx_data(d_a), .rx_valid(v_a),
    .rx_ready(rdy[0]), .parity_err(pe_a), .frame_err(fe_a), .overrun_err(ov_a), .rx_busy(bz_a));
  uart_rx_param #(.CLK_FREQ(CF), .UART_BPS(BPS), .PARITY(2)) u_b (
    .sys_clk(clk), .sys_rst(sys_rst), .uart_rxd(rxd[1]), .rx_data(d_b), .rx_valid(v_b),
    .rx_ready(rdy[1]), .parity_err(pe_b), .frame_err(fe_b), .overrun_err(ov_b), .rx_busy(bz_b));
  uart_rx_param #(.CLK_FREQ(CF), .UART_BPS(BPS), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
    .sys_clk(clk), .sys_rst(sys_rst), .uart_rxd(rxd[2]), .rx_data(d_c), .rx_valid(v_c),
    .rx_ready(rdy[2]), .parity_err(pe_c), .frame_err(fe_c), .overrun_err(ov_c), .rx_busy(bz_c));

  int DB[3] = '{8, 8, 7};
  int PB[3] = '{0, 2, 1};
  int SB[3] = '{1, 1, 2};

  typedef struct {
    int         id;
    int         done;
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } frm_t;
  frm_t pend[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // frame-level model state
  logic       m_v[3], m_pe[3], m_fe[3], m_ov[3], p_rdy[3], pv[3];
  logic [8:0] m_d[3];
  int         bz_from[3] = '{-1, -1, -1};
  int         bz_to[3]   = '{-2, -2, -2};
  logic       p_rst = 1'b0;
  bit         armed = 1'b0;
  int         rises[3] = '{0, 0, 0};
  int         ovs[3]   = '{0, 0, 0};
  int         rise_cyc[3];
  logic [8:0] last_d[3];
  logic       last_pe[3], last_fe[3];

  always @(negedge clk) begin
    logic [2:0] vv, pe, fe, ov, bz;
    logic [8:0] dd[3];
    int         k;
    vv = {v_c, v_b, v_a};  pe = {pe_c, pe_b, pe_a};  fe = {fe_c, fe_b, fe_a};
    ov = {ov_c, ov_b, ov_a};  bz = {bz_c, bz_b, bz_a};
    dd[0] = {1'b0, d_a};  dd[1] = {1'b0, d_b};  dd[2] = {2'b0, d_c};
    if (p_rst) armed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (p_rst) begin
        m_v[i] = 0; m_d[i] = 0; m_pe[i] = 0; m_fe[i] = 0; m_ov[i] = 0;
        bz_from[i] = -1; bz_to[i] = -2;
      end else begin
        k = -1;
        foreach (pend[j]) if (pend[j].id == i && pend[j].done == cyc - 1) k = j;
        m_ov[i] = 0;
        if (k >= 0) begin
          if (!m_v[i] || p_rdy[i]) begin
            m_v[i] = 1; m_d[i] = pend[k].data; m_pe[i] = pend[k].pe; m_fe[i] = pend[k].fe;
          end else m_ov[i] = 1;
          pend.delete(k);
        end else if (m_v[i] && p_rdy[i]) m_v[i] = 0;
      end
      if (armed) begin
        chk($sformatf("rx_valid%0d", i), vv[i], m_v[i]);
        chk($sformatf("overrun%0d", i), ov[i], m_ov[i]);
        chk($sformatf("busy%0d", i), bz[i], (cyc >= bz_from[i] && cyc <= bz_to[i]));
        if (m_v[i]) begin
          chk($sformatf("rx_data%0d", i), dd[i], m_d[i]);
          chk($sformatf("parity_err%0d", i), pe[i], m_pe[i]);
          chk($sformatf("frame_err%0d", i), fe[i], m_fe[i]);
        end
      end
      if (vv[i] && !pv[i]) begin
        rises[i]++; rise_cyc[i] = cyc; last_d[i] = dd[i]; last_pe[i] = pe[i]; last_fe[i] = fe[i];
      end
      if (ov[i]) ovs[i]++;
      pv[i]    = vv[i];
      p_rdy[i] = rdy[i];
    end
    if (p_rst) pend.delete();
    p_rst = sys_rst;
  end

  task automatic idle(input int c);
    repeat (c) begin @(posedge clk); #1; end
  endtask

  // Drives one frame from the current cycle n; line bit k occupies cycles n+k*B .. n+k*B+B-1.
  // The last stop bit's decision lands in cycle n + (nbits-1)*B + H + 4 (2 sync + edge detect).
  task automatic send(input int id, input logic [8:0] d, input bit bad_par, input bit stop0,
                      input int spike_at, input int abort_at, output int n);
    logic [15:0] bits;
    logic [8:0]  dm;
    logic        p;
    int          L;
    frm_t        f;
    dm = d & 9'((1 << DB[id]) - 1);
    p  = ^dm;
    if (PB[id] == 1) p = ~p;
    if (bad_par) p = ~p;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DB[id]; i++) bits[1+i] = dm[i];
    L = 1 + DB[id];
    if (PB[id] != 0) begin bits[L] = p; L++; end
    for (int s = 0; s < SB[id]; s++) begin bits[L] = ~stop0; L++; end
    n = cyc;
    f.id = id; f.done = n + (L - 1) * B + H + 4; f.data = dm;
    f.pe = bad_par && (PB[id] != 0); f.fe = stop0;
    pend.push_back(f);
    bz_from[id] = n + 3;
    bz_to[id]   = f.done;
    for (int k = 0; k < L; k++)
      for (int j = 0; j < B; j++) begin
        if (k * B + j == abort_at) begin
          rxd[id] = 1'b1; sys_rst = 1'b1;
          idle(2);
          sys_rst = 1'b0;
          return;
        end
        rxd[id] = (k * B + j == spike_at) ? ~bits[k] : bits[k];
        @(posedge clk); #1;
      end
  endtask

  // Short low pulse: detected as a start edge, rejected at the start bit's mid-point.
  task automatic glitch(input int id, input int len);
    bz_from[id] = cyc + 3;
    bz_to[id]   = cyc + H + 4;
    rxd[id] = 1'b0;
    idle(len);
    rxd[id] = 1'b1;
  endtask

  initial begin
    int n, r0, o0;
    sys_rst = 1'b1;
    idle(3);
    sys_rst = 1'b0;
    idle(5);
    chk("reset valid", v_a, 0);
    chk("reset data", d_a, 0);

    // 8N1 basic receive, latency pinned: 9 bit times + H + 5 cycles
    rdy[0] = 1'b1;
    send(0, 9'h55, 0, 0, -1, -1, n);
    idle(B);
    chk("t1 data", last_d[0], 9'h55);
    chk("t1 pe", last_pe[0], 0);
    chk("t1 fe", last_fe[0], 0);
    chk("t1 latency", rise_cyc[0], n + 480);
    chk("t1 valid low", v_a, 0);
    chk("t1 busy low", bz_a, 0);

    // even parity: correct then wrong parity bit
    rdy[1] = 1'b1;
    send(1, 9'hA3, 0, 0, -1, -1, n);
    idle(B);
    chk("t2 data0", last_d[1], 9'hA3);
    chk("t2 pe0", last_pe[1], 0);
    send(1, 9'hA3, 1, 0, -1, -1, n);
    idle(B);
    chk("t2 data1", last_d[1], 9'hA3);
    chk("t2 pe1", last_pe[1], 1);
    chk("t2 frames", rises[1], 2);

    // framing error followed by a 20-bit break
    send(0, 9'h3C, 0, 1, -1, -1, n);
    chk("t3 data", last_d[0], 9'h3C);
    chk("t3 fe", last_fe[0], 1);
    r0 = rises[0];
    idle(20 * B);
    rxd[0] = 1'b1;
    idle(2 * B);
    chk("t3 no break frame", rises[0], r0);
    send(0, 9'h81, 0, 0, -1, -1, n);
    idle(B);
    chk("t3 data2", last_d[0], 9'h81);
    chk("t3 fe2", last_fe[0], 0);

    // start glitch rejected; single-cycle spike on the middle vote of data bit 0
    r0 = rises[0];
    glitch(0, 20);
    idle(2 * B);
    chk("t4 glitch", rises[0], r0);
    send(0, 9'hF0, 0, 0, B + H + 1, -1, n);
    idle(B);
    chk("t4 spike data", last_d[0], 9'hF0);
    chk("t4 frames", rises[0], r0 + 1);

    // overrun: holder full, second frame dropped
    rdy[0] = 1'b0;
    o0 = ovs[0];
    r0 = rises[0];
    send(0, 9'h11, 0, 0, -1, -1, n);
    send(0, 9'h22, 0, 0, -1, -1, n);
    idle(B);
    chk("t5 held valid", v_a, 1);
    chk("t5 held data", d_a, 8'h11);
    chk("t5 overruns", ovs[0] - o0, 1);
    rdy[0] = 1'b1;
    idle(1);
    rdy[0] = 1'b0;
    idle(B);
    chk("t5 drained", v_a, 0);
    chk("t5 no 0x22", rises[0], r0 + 1);

    // 7O2: receive, then reset mid-data of the next frame
    send(2, 9'h5A, 0, 0, -1, -1, n);
    idle(B);
    chk("t6 data", last_d[2], 9'h5A);
    chk("t6 pe", last_pe[2], 0);
    chk("t6 fe", last_fe[2], 0);
    chk("t6 latency", rise_cyc[2], n + 530);
    chk("t6 held", v_c, 1);
    send(2, 9'h33, 0, 0, -1, 3 * B + 10, n);
    chk("t6 rst valid", v_c, 0);
    chk("t6 rst data", d_c, 0);
    chk("t6 rst busy", bz_c, 0);
    chk("t6 rst flags", {pe_c, fe_c, ov_c}, 0);
    idle(2 * B);
    rdy[2] = 1'b1;
    send(2, 9'h2B, 0, 0, -1, -1, n);
    idle(B);
    chk("t6 after rst", last_d[2], 9'h2B);
    chk("t6 after rst pe", last_pe[2], 0);

    idle(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
